// File: rtl/fifo_pkg.sv
// Shared types and sizes for the two-producer / one-consumer FIFO controller.
//   DW    : data width in bits
//   AW    : RAM address width
//   DEPTH : number of RAM entries (2**AW)
//   data_t / ptr_t / cnt_t : data word, RAM pointer, occupancy count (AW+1 bits)
package fifo_pkg;

    localparam int DW    = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    typedef logic [DW-1:0] data_t;
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    // Pointers are exactly AW bits wide, so the natural overflow of the
    // addition is the modulo-DEPTH wrap.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/fifo_arb_ctrl_if.sv
// Producer/consumer-side bundle of the FIFO controller.
//   push0_req/push0_data/push0_gnt : producer 0 write handshake
//   push1_req/push1_data/push1_gnt : producer 1 write handshake
//   pop_req/pop_ack/pop_data       : consumer read handshake (data valid in ack cycle)
//   clr_err                        : clears the sticky ovf/unf flags
//   count/empty/full/ovf/unf       : status
// Modports: master = producer/consumer logic, slave = the controller.
interface fifo_arb_ctrl_if;
    import fifo_pkg::*;

    logic  push0_req;
    data_t push0_data;
    logic  push0_gnt;
    logic  push1_req;
    data_t push1_data;
    logic  push1_gnt;
    logic  pop_req;
    logic  pop_ack;
    data_t pop_data;
    logic  clr_err;
    cnt_t  count;
    logic  empty;
    logic  full;
    logic  ovf;
    logic  unf;

    modport master (
        output push0_req, push0_data, push1_req, push1_data, pop_req, clr_err,
        input  push0_gnt, push1_gnt, pop_ack, pop_data, count, empty, full, ovf, unf
    );

    modport slave (
        input  push0_req, push0_data, push1_req, push1_data, pop_req, clr_err,
        output push0_gnt, push1_gnt, pop_ack, pop_data, count, empty, full, ovf, unf
    );

endinterface

// File: rtl/dual_port.sv
// 8x4 dual-port RAM: one synchronous write port, one combinational read port.
//   clk       : write clock
//   we_dual   : write enable
//   addr_wr   : write address
//   addr_rd   : read address
//   din       : write data
//   dout_dual : read data (combinational from addr_rd)
module dual_port
    import fifo_pkg::*;
(
    input  logic  clk,
    input  logic  we_dual,
    input  ptr_t  addr_wr,
    input  ptr_t  addr_rd,
    input  data_t din,
    output data_t dout_dual
);

    data_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_dual) begin
            mem[addr_wr] <= din;
        end
    end

    assign dout_dual = mem[addr_rd];

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a single grant per cycle.
//   clk, rst : clock, asynchronous active-low reset
//   req[1:0] : request vector
//   en       : grant enable (no grant at all while low)
//   gnt[1:0] : one-hot-or-zero grant vector (combinational)
//   onehot0  : high when gnt has at most one bit set
// last_gnt resets to 1 so requester 0 wins the first contended cycle.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       onehot0
);

    logic last_gnt_reg;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // Contention: favour whoever did not win last time.
                2'b11:   gnt = last_gnt_reg ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    assign onehot0 = ~(gnt[1] & gnt[0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt_reg <= 1'b1;
        end else if (|gnt) begin
            last_gnt_reg <= gnt[1];
        end
    end

endmodule

// File: rtl/fifo_arb_ctrl.sv
// FIFO controller that turns an external dual-port RAM into a shared queue
// for two producers and one consumer. Owns the pointers, the occupancy
// count and the sticky error flags; arbitration is delegated to rr_arb2.
//   clk, rst    : clock, asynchronous active-low reset
//   bus         : producer/consumer handshakes and status (slave modport)
//   mem_we      : RAM write enable
//   mem_addr_wr : RAM write address (write pointer)
//   mem_addr_rd : RAM read address (read pointer)
//   mem_din     : RAM write data (granted producer's data)
//   mem_dout    : RAM combinational read data (head of queue)
module fifo_arb_ctrl
    import fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    fifo_arb_ctrl_if.slave    bus,
    output logic              mem_we,
    output ptr_t              mem_addr_wr,
    output ptr_t              mem_addr_rd,
    output data_t             mem_din,
    input  data_t             mem_dout
);

    if (DEPTH != (1 << AW)) begin : g_depth_check
        $error("fifo_arb_ctrl: DEPTH must equal 2**AW");
    end

    ptr_t       wr_ptr_reg;
    ptr_t       rd_ptr_reg;
    cnt_t       count_reg;
    cnt_t       count_next;
    logic       ovf_reg;
    logic       unf_reg;
    logic       empty;
    logic       full;
    logic       push_en;
    logic       push_any;
    logic       pop_ok;
    logic [1:0] gnt;
    logic       arb_onehot0;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == cnt_t'(DEPTH));

    // Gating with rst keeps every handshake low while reset is held, even
    // though the registered state already looks empty and not full.
    assign push_en = rst & ~full;
    assign pop_ok  = rst & bus.pop_req & ~empty;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({bus.push1_req, bus.push0_req}),
        .en      (push_en),
        .gnt     (gnt),
        .onehot0 (arb_onehot0)
    );

    assign push_any = |gnt;

    always_comb begin
        count_next = count_reg;
        case ({push_any, pop_ok})
            2'b10:   count_next = count_reg + cnt_t'(1);
            2'b01:   count_next = count_reg - cnt_t'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
        end else begin
            if (push_any) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop_ok) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_next;
            // A set condition overrides a simultaneous clear.
            ovf_reg <= (full & (bus.push0_req | bus.push1_req)) | (ovf_reg & ~bus.clr_err);
            unf_reg <= (empty & bus.pop_req) | (unf_reg & ~bus.clr_err);
        end
    end

    assign bus.push0_gnt = gnt[0];
    assign bus.push1_gnt = gnt[1];
    assign bus.pop_ack   = pop_ok;
    assign bus.pop_data  = mem_dout;
    assign bus.count     = count_reg;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.ovf       = ovf_reg;
    assign bus.unf       = unf_reg;

    assign mem_we      = push_any;
    assign mem_din     = gnt[1] ? bus.push1_data : bus.push0_data;
    assign mem_addr_wr = wr_ptr_reg;
    assign mem_addr_rd = rd_ptr_reg;

    a_onehot0 : assert property (@(posedge clk) disable iff (!rst) arb_onehot0);
    a_ptr_inv : assert property (@(posedge clk) disable iff (!rst)
                                 ptr_t'(wr_ptr_reg - rd_ptr_reg) == count_reg[AW-1:0]);

endmodule
